// File: rtl/dmem_arbiter_if.sv
// Per-master request/grant bus between one memory client and dmem_arbiter.
// The client drives the request side; the arbiter answers with gnt and the
// registered read return (rvalid/rdata).
interface dmem_arbiter_if #(
    parameter int ADDR_BITS = 22,
    parameter int DATA_BITS = 32
);
    logic                 req;
    logic                 we;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [DATA_BITS-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and clear sequencer for the single-port dmem.
// After reset every implemented word is written with zero (one word per
// cycle); only then are masters granted. Grants are combinational in the
// request cycle, reads return one cycle later on the granted master's port.
// The memory array itself is never reset; this sweep is what clears it.
module dmem_arbiter #(
    parameter int ADDR_BITS = 22,
    parameter int DEPTH     = 1024,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_arbiter_if.slave        m0,
    dmem_arbiter_if.slave        m1,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_din,
    output logic                 mem_we,
    input  logic [DATA_BITS-1:0] mem_dout,
    output logic                 init_done
);
    // Highest implemented word; compared with <= so DEPTH == 2**ADDR_BITS still fits.
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] sweep_cnt;
    logic [ADDR_BITS-1:0] last_addr;   // address bus holds this while idle
    logic                 rr;          // tie winner: 0 = m0, 1 = m1
    logic                 g0;
    logic                 g1;
    logic [ADDR_BITS-1:0] sel_addr;
    logic                 sel_we;
    logic                 in_range;

    // Next state, grant decision and memory-side drive.
    always_comb begin
        // NOTE: every signal gets a default first so no branch can leave one unassigned and infer a latch.
        state_next = state;
        g0         = 1'b0;
        g1         = 1'b0;
        sel_addr   = m0.addr;
        sel_we     = 1'b0;
        in_range   = 1'b0;
        mem_addr   = last_addr;
        mem_din    = '0;
        mem_we     = 1'b0;
        case (state)
            S_INIT: begin
                mem_addr = sweep_cnt;
                mem_we   = !reset;
                if (sweep_cnt == LAST_ADDR) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                g0 = m0.req && (!m1.req || !rr);
                g1 = m1.req && (!m0.req || rr);
                if (g0 || g1) begin
                    sel_addr = g1 ? m1.addr : m0.addr;
                    sel_we   = g1 ? m1.we : m0.we;
                    in_range = (sel_addr <= LAST_ADDR);
                    mem_addr = sel_addr;
                    mem_din  = g1 ? m1.wdata : m0.wdata;
                    mem_we   = sel_we && in_range;   // out-of-range writes are dropped
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    assign m0.gnt = g0;
    assign m1.gnt = g1;

    // State register: clear sweep first, then normal arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Sweep counter, round-robin pointer, idle address hold and done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_cnt <= '0;
            rr        <= 1'b0;
            last_addr <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= (state_next == S_RUN);
            if (state == S_INIT) begin
                last_addr <= sweep_cnt;
                if (sweep_cnt != LAST_ADDR) begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                end
            end else if (g0 || g1) begin
                last_addr <= sel_addr;
                rr        <= g0;   // the other master wins the next tie
            end
        end
    end

    // Read return: capture dmem output at the grant edge, pulse rvalid once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0.rvalid <= 1'b0;
            m0.rdata  <= '0;
            m1.rvalid <= 1'b0;
            m1.rdata  <= '0;
        end else begin
            m0.rvalid <= g0 && !m0.we;
            m1.rvalid <= g1 && !m1.we;
            if (g0 && !m0.we) begin
                m0.rdata <= in_range ? mem_dout : '0;
            end
            if (g1 && !m1.we) begin
                m1.rdata <= in_range ? mem_dout : '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a 16-word memory model. Stimulus checks grants
// and the memory bus in each cycle and queues expected read data; a monitor
// pops those expectations whenever an rvalid is due or seen.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    localparam int ADDR_BITS = 22;
    localparam int DEPTH     = 16;
    localparam int DATA_BITS = 32;
    localparam int IW        = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_din;
    logic                 mem_we;
    logic [DATA_BITS-1:0] mem_dout;
    logic                 init_done;

    dmem_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) m0_if ();
    dmem_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) m1_if ();

    dmem_arbiter #(.ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH), .DATA_BITS(DATA_BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0_if),
        .m1       (m1_if),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the clock edge, preloaded
    // with non-zero garbage so the clear sweep is observable.
    logic [DATA_BITS-1:0] mem [DEPTH];
    assign mem_dout = (mem_addr < ADDR_BITS'(DEPTH)) ? mem[mem_addr[IW-1:0]] : 32'hBAD0_BAD0;
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 + i;
        forever begin
            @(posedge clk);
            if (mem_we && mem_addr < ADDR_BITS'(DEPTH)) mem[mem_addr[IW-1:0]] <= mem_din;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                   due;
        logic [DATA_BITS-1:0] data;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: read returns must appear exactly when queued, with queued data.
    always @(negedge clk) begin
        logic exp_rv0;
        logic exp_rv1;
        exp_rv0 = (q0.size() > 0) && (q0[0].due == cyc);
        exp_rv1 = (q1.size() > 0) && (q1[0].due == cyc);
        if (m0_if.rvalid || exp_rv0) begin
            check("m0_rvalid", m0_if.rvalid, exp_rv0);
            if (exp_rv0) begin
                check("m0_rdata", m0_if.rdata, q0[0].data);
                void'(q0.pop_front());
            end
        end
        if (m1_if.rvalid || exp_rv1) begin
            check("m1_rvalid", m1_if.rvalid, exp_rv1);
            if (exp_rv1) begin
                check("m1_rdata", m1_if.rdata, q1[0].data);
                void'(q1.pop_front());
            end
        end
    end

    // One RUN cycle: apply requests, check grants and memory bus, queue reads.
    task automatic drive(input string tag,
                         input logic r0, input logic w0, input logic [ADDR_BITS-1:0] a0, input logic [DATA_BITS-1:0] d0,
                         input logic r1, input logic w1, input logic [ADDR_BITS-1:0] a1, input logic [DATA_BITS-1:0] d1,
                         input logic eg0, input logic eg1,
                         input logic [DATA_BITS-1:0] er0, input logic [DATA_BITS-1:0] er1);
        logic                 w;
        logic [ADDR_BITS-1:0] a;
        logic [DATA_BITS-1:0] d;
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
        @(negedge clk);
        check({tag, " init_done"}, init_done, 1'b1);
        check({tag, " m0_gnt"}, m0_if.gnt, eg0);
        check({tag, " m1_gnt"}, m1_if.gnt, eg1);
        if (eg0 || eg1) begin
            w = eg1 ? w1 : w0;
            a = eg1 ? a1 : a0;
            d = eg1 ? d1 : d0;
            check({tag, " mem_addr"}, mem_addr, a);
            check({tag, " mem_din"}, mem_din, d);
            check({tag, " mem_we"}, mem_we, w && (a < ADDR_BITS'(DEPTH)));
            if (eg0 && !w0) q0.push_back('{cyc + 1, er0});
            if (eg1 && !w1) q1.push_back('{cyc + 1, er1});
        end else begin
            check({tag, " mem_we"}, mem_we, 1'b0);
        end
        @(posedge clk); #1;
    endtask

    // Clear sweep: DEPTH cycles of zero writes at ascending addresses, no grants.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check({tag, " mem_we"}, mem_we, 1'b1);
            check({tag, " mem_addr"}, mem_addr, i);
            check({tag, " mem_din"}, mem_din, 0);
            check({tag, " init_done"}, init_done, 1'b0);
            check({tag, " m0_gnt"}, m0_if.gnt, 1'b0);
            check({tag, " m1_gnt"}, m1_if.gnt, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // m0 requests a read of addr 3 through reset and the whole sweep.
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 3; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
        @(negedge clk);
        check("rst init_done", init_done, 1'b0);
        check("rst m0_gnt", m0_if.gnt, 1'b0);
        check("rst m1_gnt", m1_if.gnt, 1'b0);
        check("rst m0_rvalid", m0_if.rvalid, 1'b0);
        check("rst m1_rvalid", m1_if.rvalid, 1'b0);
        check("rst m0_rdata", m0_if.rdata, 0);
        check("rst m1_rdata", m1_if.rdata, 0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_din", mem_din, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        sweep_check("sweep1");

        //     tag       r0 w0 a0    d0             r1 w1 a1    d1             g0 g1 er0            er1
        drive("rd3",     1, 0, 3,    0,             0, 0, 0,    0,             1, 0, 0,             0);
        drive("wr5",     1, 1, 5,    32'hDEADBEEF,  0, 0, 0,    0,             1, 0, 0,             0);
        drive("rd5",     1, 0, 5,    0,             0, 0, 0,    0,             1, 0, 32'hDEADBEEF,  0);
        drive("wr1",     1, 1, 1,    32'h11111111,  0, 0, 0,    0,             1, 0, 0,             0);
        drive("wr2",     0, 0, 0,    0,             1, 1, 2,    32'h22222222,  0, 1, 0,             0);
        drive("both_a",  1, 0, 1,    0,             1, 0, 2,    0,             1, 0, 32'h11111111,  0);
        drive("both_b",  1, 0, 1,    0,             1, 0, 2,    0,             0, 1, 0,             32'h22222222);
        drive("both_c",  1, 0, 1,    0,             1, 0, 2,    0,             1, 0, 32'h11111111,  0);
        drive("both_d",  1, 0, 1,    0,             1, 0, 2,    0,             0, 1, 0,             32'h22222222);
        drive("wr16",    0, 0, 0,    0,             1, 1, 16,   32'hFFFFFFFF,  0, 1, 0,             0);
        drive("rd16",    0, 0, 0,    0,             1, 0, 16,   0,             0, 1, 0,             0);
        drive("rd1024",  0, 0, 0,    0,             1, 0, 1024, 0,             0, 1, 0,             0);
        drive("rd0",     1, 0, 0,    0,             0, 0, 0,    0,             1, 0, 0,             0);
        drive("wr15",    1, 1, 15,   32'h0F0F0F0F,  0, 0, 0,    0,             1, 0, 0,             0);
        drive("rd15",    1, 0, 15,   0,             0, 0, 0,    0,             1, 0, 32'h0F0F0F0F,  0);

        // Idle: bus address holds, no write, read data holds.
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        @(negedge clk);
        check("idle mem_we", mem_we, 1'b0);
        check("idle mem_addr", mem_addr, 15);
        check("idle m0_gnt", m0_if.gnt, 1'b0);
        check("idle m1_gnt", m1_if.gnt, 1'b0);
        check("idle m0_rdata_hold", m0_if.rdata, 32'h0F0F0F0F);
        @(posedge clk); #1;

        drive("m1x3_a",  0, 0, 0,    0,             1, 0, 2,    0,             0, 1, 0,             32'h22222222);
        drive("m1x3_b",  0, 0, 0,    0,             1, 0, 2,    0,             0, 1, 0,             32'h22222222);
        drive("m1x3_c",  0, 0, 0,    0,             1, 0, 2,    0,             0, 1, 0,             32'h22222222);
        drive("m0only",  1, 0, 1,    0,             0, 0, 0,    0,             1, 0, 32'h11111111,  0);
        drive("tie_a",   1, 0, 5,    0,             1, 0, 1,    0,             0, 1, 0,             32'h11111111);
        drive("tie_b",   1, 0, 5,    0,             1, 0, 1,    0,             1, 0, 32'hDEADBEEF,  0);

        // Reset lands after the grant is seen but before its edge: no rvalid.
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 5;
        m1_if.req = 1'b0;
        @(negedge clk);
        check("abort m0_gnt", m0_if.gnt, 1'b1);
        reset = 1'b1;
        #1;
        check("abort init_done", init_done, 1'b0);
        check("abort m0_rvalid", m0_if.rvalid, 1'b0);
        @(posedge clk); #1;
        check("abort m0_rvalid_after_edge", m0_if.rvalid, 1'b0);
        check("abort mem_we", mem_we, 1'b0);
        check("abort m0_rdata", m0_if.rdata, 0);
        reset = 1'b0;
        sweep_check("sweep2");

        drive("post_rd5",  1, 0, 5,  0,             0, 0, 0,    0,             1, 0, 0,             0);
        drive("post_rd15", 1, 0, 15, 0,             0, 0, 0,    0,             1, 0, 0,             0);
        drive("post_rd1",  0, 0, 0,  0,             1, 0, 1,    0,             0, 1, 0,             0);

        m0_if.req = 1'b0; m1_if.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("q0 drained", q0.size(), 0);
        check("q1 drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
